// File: rtl/axi4lite_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes, decode classes, FSM states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package axi4lite_regbank_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {CLS_RW, CLS_RO, CLS_UNMAPPED} dec_class_t;

   typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_st_t;
   typedef enum logic [0:0] {RD_IDLE, RD_RESP} rd_st_t;

   // RW registers occupy the low word indices, RO status follows, the rest is unmapped.
   function automatic dec_class_t decode_class(input int idx, input int n_rw, input int n_ro);
      if (idx < n_rw)
         return CLS_RW;
      else if (idx < n_rw + n_ro)
         return CLS_RO;
      else
         return CLS_UNMAPPED;
   endfunction

endpackage

// File: rtl/axi4lite_slave_if.sv
// AXI4-Lite handshake front-end: latches AW/W independently, issues one commit and one read sample.
// Latency: write commit 1 cycle after the later AW/W handshake, bvalid 1 cycle later; rvalid 1 cycle after AR.
// Backpressure: ready outputs stay low from their handshake until the matching B/R handshake completes.
module axi4lite_slave_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    wr_req,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    wr_ack,
   input  logic [1:0]              wr_resp,
   output logic                    rd_req,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic                    rd_ack,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic [1:0]              rd_resp
);
   import axi4lite_regbank_pkg::*;

   wr_st_t wr_st, wr_st_nx;
   rd_st_t rd_st, rd_st_nx;

   logic                    aw_held, w_held;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;
   logic                    aw_hs, w_hs, b_hs;

   assign awready = ~aw_held;
   assign wready  = ~w_held;
   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;
   assign b_hs    = bvalid & bready;

   assign wr_addr = aw_addr_q;
   assign wr_data = w_data_q;
   assign wr_strb = w_strb_q;
   assign rd_addr = araddr;

   // Capture AW and W payloads independently and keep them until the write response is taken.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
         end else if (b_hs) begin
            aw_held   <= 1'b0;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end else if (b_hs) begin
            w_held   <= 1'b0;
         end
      end
   end

   // Write FSM state register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) wr_st <= WR_COLLECT;
      else        wr_st <= wr_st_nx;
   end

   // Write FSM next state: commit once both halves are (or are becoming) held, then respond.
   always_comb begin
      wr_st_nx = wr_st;
      case (wr_st)
         WR_COLLECT: if ((aw_held | aw_hs) && (w_held | w_hs)) wr_st_nx = WR_COMMIT;
         WR_COMMIT:  if (wr_ack) wr_st_nx = WR_RESP;
         WR_RESP:    if (bready) wr_st_nx = WR_COLLECT;
         default:    wr_st_nx = WR_COLLECT;
      endcase
   end

   // Write FSM outputs.
   always_comb begin
      wr_req = (wr_st == WR_COMMIT);
      bvalid = (wr_st == WR_RESP);
   end

   // Response code is latched at commit so it stays stable while bready is low.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset)                bresp <= RESP_OKAY;
      else if (wr_req && wr_ack) bresp <= wr_resp;
   end

   // Read FSM state register.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) rd_st <= RD_IDLE;
      else        rd_st <= rd_st_nx;
   end

   // Read FSM next state: the core answers a sample request in the same cycle.
   always_comb begin
      rd_st_nx = rd_st;
      case (rd_st)
         RD_IDLE: if (rd_req && rd_ack) rd_st_nx = RD_RESP;
         RD_RESP: if (rready) rd_st_nx = RD_IDLE;
         default: rd_st_nx = RD_IDLE;
      endcase
   end

   // Read FSM outputs; the AR handshake itself is the sample request.
   always_comb begin
      arready = (rd_st == RD_IDLE);
      rvalid  = (rd_st == RD_RESP);
      rd_req  = arvalid & (rd_st == RD_IDLE);
   end

   // Read data and response are captured in the AR handshake cycle and held until rready.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdata <= '0;
         rresp <= RESP_OKAY;
      end else if (rd_req && rd_ack) begin
         rdata <= rd_data;
         rresp <= rd_resp;
      end
   end

endmodule

// File: rtl/axi4lite_regbank.sv
// AXI4-Lite register bank: N_RW byte-writable control registers followed by N_RO read-only status words.
// Latency: bvalid 2 cycles after the later AW/W handshake (ctrl_o/wr_pulse_o update with it); rvalid 1 cycle after AR.
// Backpressure: one write and one read outstanding at a time; responses held while bready/rready low.
module axi4lite_regbank #(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADDR_WIDTH = 6,
   parameter int                  N_RW       = 4,
   parameter int                  N_RO       = 4,
   parameter logic [DATA_WIDTH-1:0] RST_VAL  = '0
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ADDR_WIDTH-1:0]        awaddr,
   input  logic [2:0]                   awprot,
   input  logic                         wvalid,
   output logic                         wready,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/8-1:0]      wstrb,
   output logic                         bvalid,
   input  logic                         bready,
   output logic [1:0]                   bresp,
   input  logic                         arvalid,
   output logic                         arready,
   input  logic [ADDR_WIDTH-1:0]        araddr,
   input  logic [2:0]                   arprot,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [DATA_WIDTH-1:0]        rdata,
   output logic [1:0]                   rresp,
   output logic [N_RW*DATA_WIDTH-1:0]   ctrl_o,
   output logic [N_RW-1:0]              wr_pulse_o,
   input  logic [N_RO*DATA_WIDTH-1:0]   status_i
);
   import axi4lite_regbank_pkg::*;

   localparam int SW    = DATA_WIDTH / 8;
   localparam int OFFS  = $clog2(SW);
   localparam int IDX_W = ADDR_WIDTH - OFFS;

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi4lite_regbank: DATA_WIDTH must be 32 or 64");
   end
   if (N_RW + N_RO > (1 << IDX_W)) begin : g_bad_reg_count
      $error("axi4lite_regbank: N_RW+N_RO exceeds the decodable word range");
   end

   logic                  wr_req, wr_ack, rd_req, rd_ack;
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0] wr_data, rd_data;
   logic [SW-1:0]         wr_strb;
   logic [1:0]            wr_resp, rd_resp;

   logic [IDX_W-1:0]      wr_idx, rd_idx;
   int                    wr_idx_i, rd_idx_i;
   dec_class_t            wr_cls, rd_cls;
   logic                  wr_commit;
   logic [N_RW-1:0]       wr_hit;
   logic                  unused_ok;

   axi4lite_slave_if #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_slave_if (
      .aclk    (aclk),
      .areset  (areset),
      .awvalid (awvalid),
      .awready (awready),
      .awaddr  (awaddr),
      .wvalid  (wvalid),
      .wready  (wready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .bvalid  (bvalid),
      .bready  (bready),
      .bresp   (bresp),
      .arvalid (arvalid),
      .arready (arready),
      .araddr  (araddr),
      .rvalid  (rvalid),
      .rready  (rready),
      .rdata   (rdata),
      .rresp   (rresp),
      .wr_req  (wr_req),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_ack  (wr_ack),
      .wr_resp (wr_resp),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_ack  (rd_ack),
      .rd_data (rd_data),
      .rd_resp (rd_resp)
   );

   // Protection bits and byte-offset address bits carry no meaning here.
   assign unused_ok = ^{awprot, arprot, wr_addr[OFFS-1:0], rd_addr[OFFS-1:0]};

   assign wr_idx   = wr_addr[ADDR_WIDTH-1:OFFS];
   assign rd_idx   = rd_addr[ADDR_WIDTH-1:OFFS];
   assign wr_idx_i = 32'(wr_idx);
   assign rd_idx_i = 32'(rd_idx);
   assign wr_cls   = decode_class(wr_idx_i, N_RW, N_RO);
   assign rd_cls   = decode_class(rd_idx_i, N_RW, N_RO);

   // The core always services requests in the cycle they are raised.
   assign wr_ack    = wr_req;
   assign rd_ack    = rd_req;
   assign wr_resp   = (wr_cls == CLS_RW) ? RESP_OKAY : RESP_SLVERR;
   assign wr_commit = wr_req && (wr_cls == CLS_RW);

   for (genvar g = 0; g < N_RW; g++) begin : g_rw_reg
      logic [DATA_WIDTH-1:0] q;

      assign wr_hit[g] = wr_commit && (wr_idx_i == g);
      assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = q;

      // Byte-enabled update of one control register on a decoded commit.
      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            q <= RST_VAL;
         end else if (wr_hit[g]) begin
            for (int b = 0; b < SW; b++) begin
               if (wr_strb[b]) q[8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Commit pulse rises together with the new register value, even for an all-zero strobe.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) wr_pulse_o <= '0;
      else        wr_pulse_o <= wr_hit;
   end

   // Read mux: registers return their current (pre-commit) value, unmapped words read zero.
   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      case (rd_cls)
         CLS_RW: begin
            rd_resp = RESP_OKAY;
            for (int k = 0; k < N_RW; k++) begin
               if (rd_idx_i == k) rd_data = ctrl_o[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         CLS_RO: begin
            rd_resp = RESP_OKAY;
            for (int j = 0; j < N_RO; j++) begin
               if (rd_idx_i == N_RW + j) rd_data = status_i[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         default: begin
            rd_data = '0;
            rd_resp = RESP_SLVERR;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Directed bench for axi4lite_regbank with default parameters.
// Latency: expects bvalid 2 cycles after the later AW/W handshake, rvalid 1 cycle after AR.
// Backpressure: exercises bready/rready held low and mid-transaction reset.
module tb_axi4lite_regbank;

   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int NRW = 4;
   localparam int NRO = 4;

   logic              aclk = 1'b0;
   logic              areset;
   logic              awvalid, awready, wvalid, wready, bvalid, bready;
   logic              arvalid, arready, rvalid, rready;
   logic [AW-1:0]     awaddr, araddr;
   logic [2:0]        awprot, arprot;
   logic [DW-1:0]     wdata, rdata;
   logic [DW/8-1:0]   wstrb;
   logic [1:0]        bresp, rresp;
   logic [NRW*DW-1:0] ctrl_o;
   logic [NRW-1:0]    wr_pulse_o;
   logic [NRO*DW-1:0] status_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   axi4lite_regbank dut (
      .aclk       (aclk),
      .areset     (areset),
      .awvalid    (awvalid),
      .awready    (awready),
      .awaddr     (awaddr),
      .awprot     (awprot),
      .wvalid     (wvalid),
      .wready     (wready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .bvalid     (bvalid),
      .bready     (bready),
      .bresp      (bresp),
      .arvalid    (arvalid),
      .arready    (arready),
      .araddr     (araddr),
      .arprot     (arprot),
      .rvalid     (rvalid),
      .rready     (rready),
      .rdata      (rdata),
      .rresp      (rresp),
      .ctrl_o     (ctrl_o),
      .wr_pulse_o (wr_pulse_o),
      .status_i   (status_i)
   );

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   // mode 0: AW and W together; 1: AW then W two cycles later; 2: W then AW two cycles later.
   task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int mode, output logic [1:0] resp, output logic [NRW-1:0] pulse,
                            output int lat);
      awaddr = a; wdata = d; wstrb = s;
      if (mode == 1) begin
         awvalid = 1'b1; tick; awvalid = 1'b0; tick; wvalid = 1'b1;
      end else if (mode == 2) begin
         wvalid = 1'b1; tick; wvalid = 1'b0; tick; awvalid = 1'b1;
      end else begin
         awvalid = 1'b1; wvalid = 1'b1;
      end
      tick;
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (bvalid !== 1'b1 && lat < 10) begin tick; lat++; end
      resp = bresp; pulse = wr_pulse_o;
      bready = 1'b1; tick; bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] resp,
                           output int lat);
      araddr = a; arvalid = 1'b1;
      tick;
      arvalid = 1'b0;
      lat = 0;
      while (rvalid !== 1'b1 && lat < 10) begin tick; lat++; end
      d = rdata; resp = rresp;
      rready = 1'b1; tick; rready = 1'b0;
   endtask

   task automatic test_reset;
      areset = 1'b1;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
      status_i = '0;
      repeat (3) tick;
      areset = 1'b0;
      #1;
      n_checks++; if ({awready, wready, arready} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready}); end
      n_checks++; if ({bvalid, rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {bvalid, rvalid}); end
      n_checks++; if ({bresp, rresp} !== 4'b0000) begin n_fail++; $display("FAIL reset_resp: got %b want 0000", {bresp, rresp}); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      n_checks++; if (wr_pulse_o !== 4'b0000) begin n_fail++; $display("FAIL reset_pulse: got %b want 0000", wr_pulse_o); end
      n_checks++; if (ctrl_o !== 128'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", ctrl_o); end
   endtask

   task automatic test_aw_then_w;
      awaddr = 6'h04; awvalid = 1'b1;
      tick;
      awvalid = 1'b0;
      n_checks++; if (awready !== 1'b0) begin n_fail++; $display("FAIL aw_held_ready: got %b want 0", awready); end
      tick;
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      tick;
      wvalid = 1'b0;
      n_checks++; if ({bvalid, wr_pulse_o} !== 5'b0_0000) begin n_fail++; $display("FAIL commit_cycle: got bvalid/pulse %b want 00000", {bvalid, wr_pulse_o}); end
      tick;
      n_checks++; if (bvalid !== 1'b1) begin n_fail++; $display("FAIL aw_w_bvalid: got %b want 1", bvalid); end
      n_checks++; if (bresp !== 2'b00) begin n_fail++; $display("FAIL aw_w_bresp: got %b want 00", bresp); end
      n_checks++; if (wr_pulse_o !== 4'b0010) begin n_fail++; $display("FAIL aw_w_pulse: got %b want 0010", wr_pulse_o); end
      n_checks++; if (ctrl_o !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin n_fail++; $display("FAIL aw_w_ctrl: got %h want reg1=deadbeef", ctrl_o); end
      bready = 1'b1;
      tick;
      bready = 1'b0;
      n_checks++; if ({wr_pulse_o, bvalid} !== 5'b0000_0) begin n_fail++; $display("FAIL aw_w_after_b: got pulse/bvalid %b want 00000", {wr_pulse_o, bvalid}); end
      n_checks++; if ({awready, wready} !== 2'b11) begin n_fail++; $display("FAIL aw_w_ready_back: got %b want 11", {awready, wready}); end
   endtask

   task automatic test_w_first;
      logic [1:0] resp; logic [NRW-1:0] pulse; int lat;
      axi_write(6'h08, 32'h11223344, 4'hF, 2, resp, pulse, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL w_first_latency: got %0d want 1", lat); end
      n_checks++; if ({resp, pulse} !== 6'b00_0100) begin n_fail++; $display("FAIL w_first_resp_pulse: got %b want 000100", {resp, pulse}); end
      n_checks++; if (ctrl_o[95:64] !== 32'h11223344) begin n_fail++; $display("FAIL w_first_ctrl: got %h want 11223344", ctrl_o[95:64]); end
   endtask

   task automatic test_same_cycle_strb;
      logic [1:0] resp; logic [NRW-1:0] pulse; int lat;
      axi_write(6'h08, 32'h0000AB00, 4'h2, 0, resp, pulse, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL same_cycle_latency: got %0d want 1", lat); end
      n_checks++; if ({resp, pulse} !== 6'b00_0100) begin n_fail++; $display("FAIL strb2_resp_pulse: got %b want 000100", {resp, pulse}); end
      n_checks++; if (ctrl_o[95:64] !== 32'h1122AB44) begin n_fail++; $display("FAIL strb2_ctrl: got %h want 1122ab44", ctrl_o[95:64]); end
      // zero strobe at a non-aligned address of the same word
      axi_write(6'h0A, 32'hFFFFFFFF, 4'h0, 0, resp, pulse, lat);
      n_checks++; if ({resp, pulse} !== 6'b00_0100) begin n_fail++; $display("FAIL strb0_resp_pulse: got %b want 000100", {resp, pulse}); end
      n_checks++; if (ctrl_o[95:64] !== 32'h1122AB44) begin n_fail++; $display("FAIL strb0_ctrl: got %h want 1122ab44", ctrl_o[95:64]); end
   endtask

   task automatic test_slverr;
      logic [1:0] resp; logic [NRW-1:0] pulse; int lat;
      logic [DW-1:0] d;
      axi_write(6'h14, 32'h12345678, 4'hF, 0, resp, pulse, lat);
      n_checks++; if ({resp, pulse} !== 6'b10_0000) begin n_fail++; $display("FAIL ro_write_resp_pulse: got %b want 100000", {resp, pulse}); end
      n_checks++; if (ctrl_o !== {32'h0, 32'h1122AB44, 32'hDEADBEEF, 32'h0}) begin n_fail++; $display("FAIL ro_write_ctrl: got %h", ctrl_o); end
      axi_read(6'h24, d, resp, lat);
      n_checks++; if ({resp, d} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL read_idx9: got resp %b data %h want 10 00000000", resp, d); end
      axi_read(6'h20, d, resp, lat);
      n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL read_idx8: got resp %b want 10", resp); end
      axi_read(6'h06, d, resp, lat);
      n_checks++; if ({resp, d} !== {2'b00, 32'hDEADBEEF}) begin n_fail++; $display("FAIL read_rw1: got resp %b data %h want 00 deadbeef", resp, d); end
   endtask

   task automatic test_status_read;
      logic [1:0] resp; logic [DW-1:0] d; int lat;
      status_i = {32'h0BADC0DE, 32'h0, 32'h0, 32'hCAFEF00D};
      axi_read(6'h10, d, resp, lat);
      n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL status_latency: got %0d want 0", lat); end
      n_checks++; if ({resp, d} !== {2'b00, 32'hCAFEF00D}) begin n_fail++; $display("FAIL status0: got resp %b data %h want 00 cafef00d", resp, d); end
      axi_read(6'h1C, d, resp, lat);
      n_checks++; if ({resp, d} !== {2'b00, 32'h0BADC0DE}) begin n_fail++; $display("FAIL status3: got resp %b data %h want 00 0badc0de", resp, d); end
   endtask

   task automatic test_backpressure;
      logic [1:0] resp; logic [DW-1:0] d; int lat;
      awaddr = 6'h0C; wdata = 32'h55AA55AA; wstrb = 4'hF; araddr = 6'h10;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick;
      for (int c = 0; c < 5; c++) begin
         n_checks++; if ({bvalid, bresp} !== 3'b1_00) begin n_fail++; $display("FAIL hold_b c%0d: got %b want 100", c, {bvalid, bresp}); end
         n_checks++; if ({rvalid, rresp} !== 3'b1_00) begin n_fail++; $display("FAIL hold_r c%0d: got %b want 100", c, {rvalid, rresp}); end
         n_checks++; if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL hold_rdata c%0d: got %h want cafef00d", c, rdata); end
         n_checks++; if ({awready, wready, arready} !== 3'b000) begin n_fail++; $display("FAIL hold_ready c%0d: got %b want 000", c, {awready, wready, arready}); end
         tick;
      end
      bready = 1'b1; rready = 1'b1;
      tick;
      bready = 1'b0; rready = 1'b0;
      n_checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b00_111) begin n_fail++; $display("FAIL release: got %b want 00111", {bvalid, rvalid, awready, wready, arready}); end
      n_checks++; if (ctrl_o[127:96] !== 32'h55AA55AA) begin n_fail++; $display("FAIL hold_write_ctrl: got %h want 55aa55aa", ctrl_o[127:96]); end
      // write to reg0 commits in the same cycle the read of reg0 samples
      awaddr = 6'h00; wdata = 32'h0F0F0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick;
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 6'h00; arvalid = 1'b1;
      tick;
      arvalid = 1'b0;
      n_checks++; if ({rvalid, rdata} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL rw_collide_old: got rvalid %b rdata %h want 1 00000000", rvalid, rdata); end
      n_checks++; if ({bvalid, wr_pulse_o, ctrl_o[31:0]} !== {1'b1, 4'b0001, 32'h0F0F0F0F}) begin n_fail++; $display("FAIL rw_collide_commit: got b %b pulse %b reg0 %h", bvalid, wr_pulse_o, ctrl_o[31:0]); end
      bready = 1'b1; rready = 1'b1;
      tick;
      bready = 1'b0; rready = 1'b0;
      axi_read(6'h00, d, resp, lat);
      n_checks++; if ({resp, d} !== {2'b00, 32'h0F0F0F0F}) begin n_fail++; $display("FAIL rw_collide_new: got resp %b data %h want 00 0f0f0f0f", resp, d); end
   endtask

   task automatic test_reset_mid;
      logic any_b, any_pulse;
      awaddr = 6'h04; awvalid = 1'b1;
      tick;
      awvalid = 1'b0;
      n_checks++; if (awready !== 1'b0) begin n_fail++; $display("FAIL mid_aw_held: got %b want 0", awready); end
      #2;
      areset = 1'b1;
      #1;
      n_checks++; if ({awready, ctrl_o} !== {1'b1, 128'h0}) begin n_fail++; $display("FAIL mid_async_clear: got awready %b ctrl %h", awready, ctrl_o); end
      tick; tick;
      areset = 1'b0;
      #1;
      n_checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b111_00) begin n_fail++; $display("FAIL mid_release: got %b want 11100", {awready, wready, arready, bvalid, rvalid}); end
      wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
      tick;
      wvalid = 1'b0;
      any_b = 1'b0; any_pulse = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick;
         any_b = any_b | bvalid;
         any_pulse = any_pulse | (|wr_pulse_o);
      end
      n_checks++; if ({any_b, any_pulse} !== 2'b00) begin n_fail++; $display("FAIL mid_no_commit: got bvalid/pulse seen %b want 00", {any_b, any_pulse}); end
      n_checks++; if (ctrl_o !== 128'h0) begin n_fail++; $display("FAIL mid_regs: got %h want 0", ctrl_o); end
   endtask

   initial begin
      test_reset;
      test_aw_then_w;
      test_w_first;
      test_same_cycle_strb;
      test_slverr;
      test_status_read;
      test_backpressure;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
